// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - universal shift register built on per-bit dflipflop cells
// Hold / shift right / shift left / parallel load, with a modulo-WIDTH shift counter and word-done strobe.

module dflipflop (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_qn
);
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= 1'b0;
    else       r_q <= i_d;
  end

  assign o_q  = r_q;
  assign o_qn = ~r_q;
endmodule

module universal_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic             SinR,
  input  logic             SinL,
  input  logic [WIDTH-1:0] Pin,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic             SoutR,
  output logic             SoutL,
  output logic [CW-1:0]    Count,
  output logic             WordDone
);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    w_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             w_done;
  logic             w_done_next;
  logic             w_shift;
  logic [CW:0]      w_unused_qn;

  assign w_shift = Mode[0] ^ Mode[1];

  always_comb begin
    w_q_next = w_q;
    case (Mode)
      2'b01:   w_q_next = {SinR, w_q[WIDTH-1:1]};
      2'b10:   w_q_next = {w_q[WIDTH-2:0], SinL};
      2'b11:   w_q_next = Pin;
      default: w_q_next = w_q;
    endcase
  end

  // Out-of-range counts (non power-of-2 WIDTH) fall back to 0 on the next shift without a strobe.
  always_comb begin
    w_cnt_next  = w_cnt;
    w_done_next = 1'b0;
    if (Mode == 2'b11) begin
      w_cnt_next = '0;
    end else if (w_shift) begin
      if (w_cnt == LAST) begin
        w_cnt_next  = '0;
        w_done_next = 1'b1;
      end else if (w_cnt > LAST) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next = w_cnt + CW'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_q
    dflipflop u_ff (
      .i_clk (Clock),
      .i_rst (Reset),
      .i_d   (w_q_next[i]),
      .o_q   (w_q[i]),
      .o_qn  (Qn[i])
    );
  end

  for (genvar i = 0; i < CW; i++) begin : g_cnt
    dflipflop u_ff (
      .i_clk (Clock),
      .i_rst (Reset),
      .i_d   (w_cnt_next[i]),
      .o_q   (w_cnt[i]),
      .o_qn  (w_unused_qn[i])
    );
  end

  dflipflop u_done_ff (
    .i_clk (Clock),
    .i_rst (Reset),
    .i_d   (w_done_next),
    .o_q   (w_done),
    .o_qn  (w_unused_qn[CW])
  );

  assign Q        = w_q;
  assign SoutR    = w_q[0];
  assign SoutL    = w_q[WIDTH-1];
  assign Count    = w_cnt;
  assign WordDone = w_done;
endmodule

// File: tb/tb_universal_shift_reg.sv
// tb/tb_universal_shift_reg.sv - self-checking bench for universal_shift_reg
// Directed scenarios plus randomized operations against a shift-count reference model.

module tb_universal_shift_reg;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [1:0]    Mode;
  logic          SinR, SinL;
  logic [W-1:0]  Pin;
  logic [W-1:0]  Q, Qn;
  logic          SoutR, SoutL;
  logic [CW-1:0] Count;
  logic          WordDone;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_q;
  int           m_n;
  bit           m_done;

  universal_shift_reg #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Mode(Mode), .SinR(SinR), .SinL(SinL), .Pin(Pin),
    .Q(Q), .Qn(Qn), .SoutR(SoutR), .SoutL(SoutL), .Count(Count), .WordDone(WordDone)
  );

  always #5 Clock = ~Clock;

  task automatic model_reset();
    m_q = '0; m_n = 0; m_done = 1'b0;
  endtask

  // Drive one operation, advance the model, and step past the capturing edge.
  task automatic apply(input logic [1:0] mode, input logic sr, input logic sl, input logic [W-1:0] pin);
    Mode = mode; SinR = sr; SinL = sl; Pin = pin;
    case (mode)
      2'd1: m_q = (m_q >> 1) | (W'(sr) << (W - 1));
      2'd2: m_q = W'((m_q << 1) | W'(sl));
      2'd3: m_q = pin;
      default: ;
    endcase
    if (mode == 2'd1 || mode == 2'd2) begin
      m_n++;
      m_done = (m_n % W) == 0;
    end else begin
      m_done = 1'b0;
      if (mode == 2'd3) m_n = 0;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Mode = 2'd0; SinR = 0; SinL = 0; Pin = '0;
    model_reset();
    #2;
    n_checks++; if (Q !== 4'b0000) begin n_errors++; $display("FAIL reset_q: got %b expected 0000", Q); end
    n_checks++; if (Qn !== 4'b1111) begin n_errors++; $display("FAIL reset_qn: got %b expected 1111", Qn); end
    n_checks++; if (Count !== 2'd0 || WordDone !== 1'b0) begin n_errors++; $display("FAIL reset_cnt: got %0d/%b expected 0/0", Count, WordDone); end
    @(posedge Clock); #1;
    Reset = 1'b0;
    apply(2'd3, 0, 0, 4'b1011);
    apply(2'd1, 0, 0, '0);
    n_checks++; if (Count !== 2'd1) begin n_errors++; $display("FAIL pre_reset_cnt: got %0d expected 1", Count); end
    #1 Reset = 1'b1;
    #1;
    model_reset();
    n_checks++; if (Q !== 4'b0000 || Qn !== 4'b1111) begin n_errors++; $display("FAIL async_reset_q: got %b/%b expected 0000/1111", Q, Qn); end
    n_checks++; if (Count !== 2'd0 || WordDone !== 1'b0) begin n_errors++; $display("FAIL async_reset_cnt: got %0d/%b expected 0/0", Count, WordDone); end
    #1 Reset = 1'b0;
  endtask

  task automatic test_load_hold();
    apply(2'd3, 0, 0, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (Q !== 4'b1010 || Qn !== 4'b0101) begin n_errors++; $display("FAIL load_hold_q[%0d]: got %b/%b expected 1010/0101", i, Q, Qn); end
      n_checks++; if (Count !== 2'd0 || WordDone !== 1'b0) begin n_errors++; $display("FAIL load_hold_cnt[%0d]: got %0d/%b expected 0/0", i, Count, WordDone); end
      if (i < 3) apply(2'd0, 1, 1, 4'b1111);
    end
  endtask

  task automatic test_serialize_right();
    logic [3:0] exp_out;
    logic [7:0] exp_cnt;
    exp_out = 4'b1101;
    exp_cnt = 8'b00_11_10_01;
    apply(2'd3, 0, 0, 4'b1101);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (SoutR !== exp_out[i]) begin n_errors++; $display("FAIL ser_right_sout[%0d]: got %b expected %b", i, SoutR, exp_out[i]); end
      apply(2'd1, 0, 0, '0);
      n_checks++; if (Count !== exp_cnt[2*i +: 2]) begin n_errors++; $display("FAIL ser_right_cnt[%0d]: got %0d expected %0d", i, Count, exp_cnt[2*i +: 2]); end
      n_checks++; if (WordDone !== (i == 3)) begin n_errors++; $display("FAIL ser_right_done[%0d]: got %b expected %b", i, WordDone, i == 3); end
    end
    n_checks++; if (Q !== 4'b0000) begin n_errors++; $display("FAIL ser_right_q: got %b expected 0000", Q); end
  endtask

  task automatic test_deserialize_left();
    logic [3:0] stream;
    stream = 4'b1001;
    Reset = 1'b1; #2 Reset = 1'b0;
    model_reset();
    for (int i = 3; i >= 0; i--) apply(2'd2, 0, stream[i], '0);
    n_checks++; if (Q !== 4'b1001) begin n_errors++; $display("FAIL deser_left_q: got %b expected 1001", Q); end
    n_checks++; if (WordDone !== 1'b1) begin n_errors++; $display("FAIL deser_left_done: got %b expected 1", WordDone); end
    apply(2'd0, 0, 0, '0);
    n_checks++; if (WordDone !== 1'b0 || Q !== 4'b1001) begin n_errors++; $display("FAIL deser_left_hold: got %b/%b expected 0/1001", WordDone, Q); end
  endtask

  task automatic test_load_interrupt();
    apply(2'd3, 0, 0, 4'b1111);
    apply(2'd1, 1, 0, '0);
    apply(2'd1, 1, 0, '0);
    n_checks++; if (Count !== 2'd2) begin n_errors++; $display("FAIL intr_cnt2: got %0d expected 2", Count); end
    apply(2'd3, 0, 0, 4'b0110);
    n_checks++; if (Q !== 4'b0110 || Count !== 2'd0 || WordDone !== 1'b0) begin n_errors++; $display("FAIL intr_load: got %b/%0d/%b expected 0110/0/0", Q, Count, WordDone); end
    for (int i = 0; i < 4; i++) begin
      apply(2'd2, 0, 1, '0);
      n_checks++; if (WordDone !== (i == 3)) begin n_errors++; $display("FAIL intr_done[%0d]: got %b expected %b", i, WordDone, i == 3); end
    end
  endtask

  task automatic test_mixed();
    logic [7:0] modes;
    modes = 8'b10_01_10_10;
    apply(2'd3, 0, 0, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      apply(modes[2*i +: 2], 0, 0, '0);
      n_checks++; if (Qn !== ~Q || Q !== m_q) begin n_errors++; $display("FAIL mixed_qn[%0d]: got %b/%b expected %b/%b", i, Q, Qn, m_q, ~m_q); end
    end
    n_checks++; if (Q !== 4'b0100 || Count !== 2'd0 || WordDone !== 1'b1) begin n_errors++; $display("FAIL mixed_end: got %b/%0d/%b expected 0100/0/1", Q, Count, WordDone); end
  endtask

  task automatic test_random();
    logic [1:0] md;
    for (int i = 0; i < 300; i++) begin
      md = 2'($urandom_range(0, 3));
      if (md == 2'd3 && $urandom_range(0, 3) != 0) md = 2'($urandom_range(1, 2));
      apply(md, 1'($urandom), 1'($urandom), W'($urandom));
      n_checks++; if (Q !== m_q || Qn !== ~m_q) begin n_errors++; $display("FAIL rand_q[%0d]: got %b/%b expected %b/%b", i, Q, Qn, m_q, ~m_q); end
      n_checks++; if (SoutR !== m_q[0] || SoutL !== m_q[W-1]) begin n_errors++; $display("FAIL rand_sout[%0d]: got %b%b expected %b%b", i, SoutL, SoutR, m_q[W-1], m_q[0]); end
      n_checks++; if (Count !== CW'(m_n % W)) begin n_errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, Count, m_n % W); end
      n_checks++; if (WordDone !== m_done) begin n_errors++; $display("FAIL rand_done[%0d]: got %b expected %b", i, WordDone, m_done); end
    end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_serialize_right();
    test_deserialize_left();
    test_load_interrupt();
    test_mixed();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
